// File: rtl/param_counter.sv
`timescale 1ns/1ps
// Purpose : parametrised up/down counter with wrap/saturate limits, load and limit flags.
// Latency : data/rollover one clock after the sampled enable or load; terminal is combinational.
// Backpr. : none; the counter accepts a command on every clock edge.
//
// Ports:
//   clock_i      counter clock, rising edge
//   clear_i      asynchronous reset, active-high (data -> RESET_VAL, flags -> 0)
//   enable_i     count enable; the counter steps only when high
//   up_down_i    1 = count up, 0 = count down (takes effect on the same edge)
//   load_i       synchronous load strobe; overrides enable
//   load_data_i  value to load, clamped to MAX_COUNT
//   data_o       registered count value
//   terminal_o   the step about to be taken on the next edge hits a limit
//   rollover_o   one-cycle pulse in the cycle after a limit step
//   ovf_sticky_o sticky overflow flag        (PARAM_COUNTER_OVF_STICKY_EN only)
//   ovf_ack_i    clears ovf_sticky_o         (PARAM_COUNTER_OVF_STICKY_EN only)
//
// Optional feature macro: PARAM_COUNTER_OVF_STICKY_EN adds the sticky overflow flag
// and its acknowledge input. Without it neither port nor the sticky flop exists.

module param_counter #(
  parameter int unsigned     WIDTH     = 16,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     MODE      = 0,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             terminal_o,
  output logic             rollover_o
`ifdef PARAM_COUNTER_OVF_STICKY_EN
  ,
  output logic             ovf_sticky_o,
  input  logic             ovf_ack_i
`endif
);

  // ---------------------------------------------------------------------------
  // Parameter legality. Any bad combination stops elaboration.
  // WIDTH is capped at 63 so the full-scale value still fits a 64-bit constant.
  // ---------------------------------------------------------------------------
  localparam longint unsigned FULL_SCALE = (WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                         : ((64'd1 << WIDTH) - 64'd1);

  generate
    if (WIDTH < 2 || WIDTH > 63) begin : g_bad_width
      $error("param_counter: WIDTH must be in 2..63");
    end
    if (MAX_COUNT == 0 || MAX_COUNT > FULL_SCALE) begin : g_bad_max
      $error("param_counter: MAX_COUNT must be in 1..2**WIDTH-1");
    end
    if (RESET_VAL > MAX_COUNT) begin : g_bad_reset
      $error("param_counter: RESET_VAL must not exceed MAX_COUNT");
    end
    if (MODE > 1) begin : g_bad_mode
      $error("param_counter: MODE must be 0 (wrap) or 1 (saturate)");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Constants in counter width
  // ---------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] MAX_V  = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Value taken when stepping past a limit: wrap jumps to the opposite limit,
  // saturate stays on the limit just reached.
  localparam logic [WIDTH-1:0] PAST_MAX_V  = (MODE == 1) ? MAX_V  : ZERO_V;
  localparam logic [WIDTH-1:0] PAST_ZERO_V = (MODE == 1) ? ZERO_V : MAX_V;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q, data_d;
  logic             rollover_q, rollover_d;

  // ---------------------------------------------------------------------------
  // Limit detection
  // ---------------------------------------------------------------------------
  logic at_max;
  logic at_zero;
  logic at_limit;
  logic step_en;
  logic limit_step;

  always_comb begin
    at_max     = (data_q == MAX_V);
    at_zero    = (data_q == ZERO_V);
    // The relevant limit depends on the direction presented this cycle.
    at_limit   = up_down_i ? at_max : at_zero;
    // Load outranks the count enable, so a load cycle never counts as a step.
    step_en    = enable_i & ~load_i;
    limit_step = step_en & at_limit;
  end

  // ---------------------------------------------------------------------------
  // Load value clamp: anything above the terminal value loads the terminal value,
  // so the register never holds a value outside 0..MAX_COUNT.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] load_val;

  always_comb begin
    load_val = load_data_i;
    if (load_data_i > MAX_V) begin
      load_val = MAX_V;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] step_val;

  always_comb begin
    // Only the non-limit branches do arithmetic, so +1 / -1 can never leave the
    // 0..MAX_COUNT range and no wider intermediate is needed.
    step_val = data_q;
    if (up_down_i) begin
      step_val = at_max ? PAST_MAX_V : (data_q + ONE_V);
    end else begin
      step_val = at_zero ? PAST_ZERO_V : (data_q - ONE_V);
    end
  end

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_val;
    end else if (enable_i) begin
      data_d = step_val;
    end
  end

  // Pulses in both modes, including a saturating hold at the limit.
  always_comb begin
    rollover_d = limit_step;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      data_q     <= RST_V;
      rollover_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      rollover_q <= rollover_d;
    end
  end

`ifdef PARAM_COUNTER_OVF_STICKY_EN
  // ---------------------------------------------------------------------------
  // Sticky overflow: sets together with rollover and holds until acknowledged.
  // A new limit step in the acknowledge cycle wins so no overflow is lost.
  // ---------------------------------------------------------------------------
  logic ovf_sticky_q, ovf_sticky_d;

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (limit_step) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_ack_i) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky_o = ovf_sticky_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_o     = data_q;
  assign rollover_o = rollover_q;
  assign terminal_o = limit_step;

endmodule

// File: tb/tb_param_counter.sv
`timescale 1ns/1ps
// Purpose : random + directed scoreboard bench for param_counter, three configurations
//           (16-bit defaults; 0..9 wrap; 0..9 saturate with non-zero reset value).
// Latency : expectations are queued per cycle and compared before and after each edge.
// Backpr. : not applicable; the DUTs accept a command every cycle.

module tb_param_counter;

  logic        clk;
  logic        clear;
  logic        enable;
  logic        up_down;
  logic        load;
  logic [15:0] ldd;
  logic        ack;

  logic [15:0] d0;
  logic [3:0]  d1;
  logic [3:0]  d2;
  logic [2:0]  term_w;
  logic [2:0]  roll_w;
`ifdef PARAM_COUNTER_OVF_STICKY_EN
  logic [2:0]  stk_w;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_counter #(.WIDTH(16)) dut0 (
    .clock_i(clk), .clear_i(clear), .enable_i(enable), .up_down_i(up_down),
    .load_i(load), .load_data_i(ldd), .data_o(d0),
    .terminal_o(term_w[0]), .rollover_o(roll_w[0])
`ifdef PARAM_COUNTER_OVF_STICKY_EN
    , .ovf_sticky_o(stk_w[0]), .ovf_ack_i(ack)
`endif
  );

  param_counter #(.WIDTH(4), .MAX_COUNT(9), .MODE(0)) dut1 (
    .clock_i(clk), .clear_i(clear), .enable_i(enable), .up_down_i(up_down),
    .load_i(load), .load_data_i(ldd[3:0]), .data_o(d1),
    .terminal_o(term_w[1]), .rollover_o(roll_w[1])
`ifdef PARAM_COUNTER_OVF_STICKY_EN
    , .ovf_sticky_o(stk_w[1]), .ovf_ack_i(ack)
`endif
  );

  param_counter #(.WIDTH(4), .MAX_COUNT(9), .MODE(1), .RESET_VAL(5)) dut2 (
    .clock_i(clk), .clear_i(clear), .enable_i(enable), .up_down_i(up_down),
    .load_i(load), .load_data_i(ldd[3:0]), .data_o(d2),
    .terminal_o(term_w[2]), .rollover_o(roll_w[2])
`ifdef PARAM_COUNTER_OVF_STICKY_EN
    , .ovf_sticky_o(stk_w[2]), .ovf_ack_i(ack)
`endif
  );

  // Reference model configuration, one entry per DUT.
  int MAXV [3] = '{65535, 9, 9};
  int SAT  [3] = '{0, 0, 1};
  int RSTV [3] = '{0, 0, 5};
  int LMASK[3] = '{65535, 15, 15};

  // Model state.
  int cnt [3];
  bit roll[3];
  bit stk [3];

  typedef struct packed {
    logic [2:0][15:0] pre_d;
    logic [2:0]       pre_r;
    logic [2:0]       pre_s;
    logic [2:0]       term;
    logic [2:0][15:0] post_d;
    logic [2:0]       post_r;
    logic [2:0]       post_s;
  } rec_t;

  rec_t sb[$];

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] act_d(input int k);
    case (k)
      0:       return d0;
      1:       return {12'd0, d1};
      default: return {12'd0, d2};
    endcase
  endfunction

  // One stimulus cycle: drive inputs at the falling edge, predict the state the
  // DUTs show before the next rising edge and the state they take at it.
  task automatic cyc(input bit en, input bit ud, input bit ld, input logic [15:0] v,
                     input bit clr, input bit ak);
    rec_t r;
    int   nxt;
    bit   lim;
    @(negedge clk);
    enable = en; up_down = ud; load = ld; ldd = v; clear = clr; ack = ak;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        cnt[k] = RSTV[k]; roll[k] = 1'b0; stk[k] = 1'b0;
      end
      r.pre_d[k] = cnt[k][15:0];
      r.pre_r[k] = roll[k];
      r.pre_s[k] = stk[k];
      nxt = cnt[k];
      lim = 1'b0;
      if (ld) begin
        nxt = int'(v) & LMASK[k];
        if (nxt > MAXV[k]) nxt = MAXV[k];
      end else if (en) begin
        nxt = ud ? cnt[k] + 1 : cnt[k] - 1;
        if (nxt > MAXV[k]) begin
          lim = 1'b1; nxt = SAT[k] ? MAXV[k] : 0;
        end else if (nxt < 0) begin
          lim = 1'b1; nxt = SAT[k] ? 0 : MAXV[k];
        end
      end
      r.term[k] = lim;
      if (clr) begin
        cnt[k] = RSTV[k]; roll[k] = 1'b0; stk[k] = 1'b0;
      end else begin
        cnt[k]  = nxt;
        roll[k] = lim;
        stk[k]  = lim ? 1'b1 : (ak ? 1'b0 : stk[k]);
      end
      r.post_d[k] = cnt[k][15:0];
      r.post_r[k] = roll[k];
      r.post_s[k] = stk[k];
    end
    sb.push_back(r);
  endtask

  // Monitor: pre-edge view (incl. combinational terminal) mid low phase,
  // post-edge view just after the rising edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() != 0) begin
        r = sb[0];
        for (int k = 0; k < 3; k++) begin
          chk("pre_data", k, act_d(k), r.pre_d[k]);
          chk("pre_rollover", k, {15'd0, roll_w[k]}, {15'd0, r.pre_r[k]});
          chk("terminal", k, {15'd0, term_w[k]}, {15'd0, r.term[k]});
`ifdef PARAM_COUNTER_OVF_STICKY_EN
          chk("pre_sticky", k, {15'd0, stk_w[k]}, {15'd0, r.pre_s[k]});
`endif
        end
      end
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        r = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk("data", k, act_d(k), r.post_d[k]);
          chk("rollover", k, {15'd0, roll_w[k]}, {15'd0, r.post_r[k]});
`ifdef PARAM_COUNTER_OVF_STICKY_EN
          chk("sticky", k, {15'd0, stk_w[k]}, {15'd0, r.post_s[k]});
`endif
        end
      end
    end
  end

  initial begin
    logic [15:0] pick [8];
    logic [15:0] v;
    pick = '{16'h0000, 16'h0001, 16'h0009, 16'h000A, 16'h000F, 16'hFFFE, 16'hFFFF, 16'h1234};
    clear = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; ldd = 16'h0; ack = 1'b0;

    // Reset, then clear asserted mid-count from 0x1234.
    cyc(0, 1, 0, 16'h0, 1, 0);
    cyc(0, 1, 0, 16'h0, 0, 0);
    cyc(0, 1, 1, 16'h1234, 0, 0);
    cyc(1, 1, 0, 16'h0, 0, 0);
    cyc(1, 1, 0, 16'h0, 1, 0);
    cyc(1, 1, 0, 16'h0, 0, 0);

    // Wrap up from 0 for 12 clocks.
    cyc(0, 1, 1, 16'h0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 16'h0, 0, 0);

    // Sticky held for 10 cycles, acknowledged, then ack coincident with a wrap.
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 16'h0, 0, 0);
    cyc(0, 1, 0, 16'h0, 0, 1);
    cyc(0, 1, 1, 16'h9, 0, 0);
    cyc(1, 1, 0, 16'h0, 0, 1);
    cyc(0, 1, 0, 16'h0, 0, 0);

    // Saturate/wrap down: load 2, down x4.
    cyc(0, 0, 1, 16'h2, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 16'h0, 0, 0);

    // Load priority and clamp, then step up from the terminal value.
    cyc(1, 1, 1, 16'hF, 0, 0);
    cyc(1, 1, 0, 16'h0, 0, 0);

    // Direction and enable: up to 5, then down with enable 1,0,1.
    cyc(0, 1, 1, 16'h0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 16'h0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 0);

    // Randomised traffic, loads biased toward the limits.
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : 16'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0, v,
          $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 0, 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
